trng_sample_sequencer: RTL and testbench
========================================

// Module: trng_sample_sequencer
// PURPOSE
//   Sequences one TRNG core: powers the two ring oscillators, waits for them to settle and samples one raw bit every SAMPLE_DIV cycles.
//   Packs 8 raw bits per word and whitens the word through the shared ascon S-box. Offers each word on a valid/ready port.
//   Runs a repetition-count health test and latches a sticky failure. Sits between the top-level pins and the RO counter / S-box instances.
// PARAMETERS
//   SETTLE_CYCLES  16  cycles ROs run after activation before the first sample
//   SAMPLE_DIV     4   cycles between raw samples (>=1)
//   SBOX_LAT       1   registered latency of the S-box, in cycles
//   REP_LIMIT      32  identical consecutive raw samples that trip the health test
// PORTS
//   clk            in   1  system clock
//   rst_n          in   1  synchronous reset, ACTIVE-HIGH (name kept for codebase consistency)
//   start          in   1  level enable; high = produce words continuously
//   sel_cfg        in   3  RO output select; latched in IDLE when start rises
//   ro_bit_in      in   1  raw entropy bit from the RO counter output
//   ro_activate_1  out  1  RO 1 enable
//   ro_activate_2  out  1  RO 2 enable
//   out_sel        out  3  latched sel_cfg, to the RO counter
//   sbox_activate  out  1  S-box enable
//   sbox_in        out  5  S-box operand
//   sbox_out       in   5  S-box result
//   rnd_data       out  8  whitened random word
//   rnd_valid      out  1  rnd_data valid
//   rnd_ready      in   1  consumer accepts the word
//   busy           out  1  high in any state except IDLE or FAIL
//   health_fail    out  1  sticky health-test failure
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; shift register, counters and latched sel cleared. Reset overrides all other events in every state.
//   IDLE: ROs off. If start=1: latch sel_cfg into out_sel, clear the settle counter, go to WARMUP.
//   WARMUP: ro_activate_1 and ro_activate_2 = 1. After SETTLE_CYCLES cycles in WARMUP go to SAMPLE; bit count=0, divider=0.
//   SAMPLE: ROs stay on. Divider counts 0..SAMPLE_DIV-1. When divider = SAMPLE_DIV-1:
//     shreg <= {shreg[6:0], ro_bit_in}; bit count +1.
//     On the 8th bit go to WHITEN.
//   WHITEN: sbox_in = shreg[4:0], held. sbox_activate = 1 for SBOX_LAT+1 cycles.
//     On the last of those cycles: rnd_data <= shreg ^ {3'b000, sbox_out}. Go to PRESENT.
//   PRESENT: rnd_valid = 1. rnd_data is held stable until rnd_valid && rnd_ready.
//     On handshake, start=1: go to SAMPLE with no re-warmup. start=0: go to IDLE.
//     rnd_valid drops in the cycle after the handshake.
//   start=0 during WARMUP or SAMPLE: abort to IDLE next cycle. Partial bits are discarded and the ROs turn off.
//   start=0 during WHITEN or PRESENT: the word completes and is delivered, then the block goes to IDLE.
//   sel_cfg changes outside IDLE are ignored.
//   Health test (repetition count):
//     Evaluated on every raw sample. Equal to the previous sample: rep counter +1; different: rep counter = 1.
//     The first sample after WARMUP sets the counter to 1.
//     Counter reaches REP_LIMIT: go to FAIL on the next cycle, pre-empting any transition.
//   FAIL: ROs off, sbox_activate=0, rnd_valid=0, busy=0, health_fail=1. Leaves FAIL only on reset.
//   Widths: settle, divider and rep counters sized with $clog2(param+1). No counter wraps; each saturates at its terminal value.
// STRUCTURE
//   trng_pkg: state enum (IDLE, WARMUP, SAMPLE, WHITEN, PRESENT, FAIL), WORD_W=8, SBOX_W=5, default parameter constants.
//   Sub-module trng_health_rct: inputs clk, rst_n, clr, sample_en, bit_in; output fail.
//   The FSM, counters, shift register and output register stay in this module.
// TESTING
//   1. start=1, ro_bit_in toggles each sample, rnd_ready=1 -> first rnd_valid exactly SETTLE_CYCLES+8*SAMPLE_DIV+SBOX_LAT+1 cycles after start, with rnd_data = shreg ^ sbox_out.
//   2. rnd_ready held 0 for 20 cycles in PRESENT -> rnd_valid stays 1, rnd_data constant, no sampling. Raise ready -> next word with no warmup gap.
//   3. start dropped after 3 raw bits -> IDLE next cycle, ROs 0. A later start re-warms and the word contains no stale bits.
//   4. ro_bit_in stuck at 1 -> health_fail=1 after REP_LIMIT=32 samples, ROs off, rnd_valid=0. Stays set despite start toggling until rst_n=1.
//   5. rst_n=1 pulsed mid-WHITEN -> next cycle all outputs 0, state IDLE.
//   6. sel_cfg=3'd5 at start, changed to 3'd2 mid-run -> out_sel stays 5 until the next IDLE->WARMUP.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG sample sequencer and its health test.
package trng_pkg;

   localparam int WORD_W = 8;
   localparam int SBOX_W = 5;

   localparam int DEF_SETTLE_CYCLES = 16;
   localparam int DEF_SAMPLE_DIV    = 4;
   localparam int DEF_SBOX_LAT      = 1;
   localparam int DEF_REP_LIMIT     = 32;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WARMUP  = 3'd1,
      ST_SAMPLE  = 3'd2,
      ST_WHITEN  = 3'd3,
      ST_PRESENT = 3'd4,
      ST_FAIL    = 3'd5
   } trng_state_e;

endpackage

// File: rtl/trng_sample_sequencer_if.sv
// Valid/ready port carrying whitened random words to the consumer.
interface trng_sample_sequencer_if;
   import trng_pkg::*;

   logic [WORD_W-1:0] rnd_data;
   logic              rnd_valid;
   logic              rnd_ready;

   modport master (output rnd_data, output rnd_valid, input rnd_ready);
   modport slave  (input rnd_data, input rnd_valid, output rnd_ready);

endinterface

// File: rtl/trng_health_rct.sv
// Repetition-count health test: flags when REP_LIMIT identical raw samples arrive in a row.
module trng_health_rct #(
   parameter int REP_LIMIT = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic sample_en,
   input  logic bit_in,
   output logic fail
);

   localparam int               CNT_W   = $clog2(REP_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REP_LIMIT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_reg;
   logic             prev_reg;

   // A zero count means no previous sample exists yet, so the next one starts a run of 1.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         cnt_reg  <= '0;
         prev_reg <= 1'b0;
      end else if (clr) begin
         cnt_reg  <= '0;
         prev_reg <= 1'b0;
      end else if (sample_en) begin
         prev_reg <= bit_in;
         if (cnt_reg == '0 || bit_in != prev_reg) begin
            cnt_reg <= CNT_ONE;
         end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + CNT_ONE;
         end
      end
   end

   assign fail = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/trng_sample_sequencer.sv
// Sequences one TRNG core: RO warm-up, divided raw sampling, S-box whitening,
// valid/ready word delivery and a sticky repetition-count failure state.
module trng_sample_sequencer
   import trng_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SAMPLE_DIV    = DEF_SAMPLE_DIV,
   parameter int SBOX_LAT      = DEF_SBOX_LAT,
   parameter int REP_LIMIT     = DEF_REP_LIMIT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [2:0]              sel_cfg,
   input  logic                    ro_bit_in,
   output logic                    ro_activate_1,
   output logic                    ro_activate_2,
   output logic [2:0]              out_sel,
   output logic                    sbox_activate,
   output logic [SBOX_W-1:0]       sbox_in,
   input  logic [SBOX_W-1:0]       sbox_out,
   trng_sample_sequencer_if.master rnd,
   output logic                    busy,
   output logic                    health_fail
);

   localparam logic [2:0] S_IDLE    = ST_IDLE;
   localparam logic [2:0] S_WARMUP  = ST_WARMUP;
   localparam logic [2:0] S_SAMPLE  = ST_SAMPLE;
   localparam logic [2:0] S_WHITEN  = ST_WHITEN;
   localparam logic [2:0] S_PRESENT = ST_PRESENT;
   localparam logic [2:0] S_FAIL    = ST_FAIL;

   localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
   localparam int DIV_W    = $clog2(SAMPLE_DIV + 1);
   localparam int WH_W     = $clog2(SBOX_LAT + 2);
   localparam int BIT_W    = $clog2(WORD_W + 1);

   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
   localparam logic [DIV_W-1:0]    DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [WH_W-1:0]     WH_LAST     = WH_W'(SBOX_LAT);
   localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(WORD_W - 1);

   logic [2:0]          state_reg, state_next;
   logic [SETTLE_W-1:0] settle_reg;
   logic [DIV_W-1:0]    div_reg;
   logic [WH_W-1:0]     whiten_reg;
   logic [BIT_W-1:0]    bit_cnt_reg;
   logic [WORD_W-1:0]   shreg_reg;
   logic [WORD_W-1:0]   rnd_data_reg;
   logic [2:0]          out_sel_reg;
   logic [WORD_W-1:0]   whitened;

   logic sample_tick;
   logic rct_clr;
   logic rct_fail;

   assign sample_tick = (state_reg == S_SAMPLE) && (div_reg == DIV_LAST);
   assign rct_clr     = (state_reg == S_IDLE) || (state_reg == S_WARMUP);

   trng_health_rct #(
      .REP_LIMIT (REP_LIMIT)
   ) u_health (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (rct_clr),
      .sample_en (sample_tick && start),
      .bit_in    (ro_bit_in),
      .fail      (rct_fail)
   );

   // Only the low SBOX_W bits are mixed with the S-box result; the rest pass through.
   genvar gi;
   for (gi = 0; gi < WORD_W; gi++) begin : g_whiten
      if (gi < SBOX_W) begin : g_mix
         assign whitened[gi] = shreg_reg[gi] ^ sbox_out[gi];
      end else begin : g_pass
         assign whitened[gi] = shreg_reg[gi];
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) state_next = S_WARMUP;
         end
         S_WARMUP: begin
            if (!start)                         state_next = S_IDLE;
            else if (settle_reg == SETTLE_LAST) state_next = S_SAMPLE;
         end
         S_SAMPLE: begin
            if (!start)                                   state_next = S_IDLE;
            else if (sample_tick && bit_cnt_reg == BIT_LAST) state_next = S_WHITEN;
         end
         S_WHITEN: begin
            if (whiten_reg == WH_LAST) state_next = S_PRESENT;
         end
         S_PRESENT: begin
            if (rnd.rnd_ready) state_next = start ? S_SAMPLE : S_IDLE;
         end
         S_FAIL: begin
            state_next = S_FAIL;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
      // A tripped health test wins over every other transition.
      if (rct_fail) state_next = S_FAIL;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_reg    <= S_IDLE;
         settle_reg   <= '0;
         div_reg      <= '0;
         whiten_reg   <= '0;
         bit_cnt_reg  <= '0;
         shreg_reg    <= '0;
         rnd_data_reg <= '0;
         out_sel_reg  <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               settle_reg  <= '0;
               div_reg     <= '0;
               whiten_reg  <= '0;
               bit_cnt_reg <= '0;
               shreg_reg   <= '0;
               if (start) out_sel_reg <= sel_cfg;
            end
            S_WARMUP: begin
               if (settle_reg != SETTLE_LAST) settle_reg <= settle_reg + SETTLE_W'(1);
               div_reg     <= '0;
               bit_cnt_reg <= '0;
            end
            S_SAMPLE: begin
               whiten_reg <= '0;
               if (div_reg == DIV_LAST) begin
                  div_reg     <= '0;
                  shreg_reg   <= {shreg_reg[WORD_W-2:0], ro_bit_in};
                  bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
               end else begin
                  div_reg <= div_reg + DIV_W'(1);
               end
            end
            S_WHITEN: begin
               if (whiten_reg == WH_LAST) rnd_data_reg <= whitened;
               else                       whiten_reg   <= whiten_reg + WH_W'(1);
            end
            S_PRESENT: begin
               div_reg     <= '0;
               bit_cnt_reg <= '0;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy          = (state_reg != S_IDLE) && (state_reg != S_FAIL);
   assign ro_activate_1 = busy;
   assign ro_activate_2 = busy;
   assign out_sel       = out_sel_reg;
   assign sbox_activate = (state_reg == S_WHITEN);
   assign sbox_in       = (state_reg == S_WHITEN) ? shreg_reg[SBOX_W-1:0] : '0;
   assign rnd.rnd_data  = rnd_data_reg;
   assign rnd.rnd_valid = (state_reg == S_PRESENT);
   assign health_fail   = (state_reg == S_FAIL);

endmodule

// File: tb/tb_trng_sample_sequencer.sv
// Directed-sequence bench with randomized entropy bits; words and timing are predicted
// from the raw bits driven at each expected sample instant and the ascon S-box table.
module tb_trng_sample_sequencer;

   localparam int SETTLE   = 16;
   localparam int DIV      = 4;
   localparam int SBOX_LAT = 1;
   localparam int REP      = 32;
   localparam int WORD_LAT = 8 * DIV + SBOX_LAT + 1;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [2:0] sel_cfg;
   logic       ro_bit_in;
   logic       ro_activate_1;
   logic       ro_activate_2;
   logic [2:0] out_sel;
   logic       sbox_activate;
   logic [4:0] sbox_in;
   logic [4:0] sbox_out;
   logic       busy;
   logic       health_fail;

   trng_sample_sequencer_if rnd_if();

   trng_sample_sequencer #(
      .SETTLE_CYCLES (SETTLE),
      .SAMPLE_DIV    (DIV),
      .SBOX_LAT      (SBOX_LAT),
      .REP_LIMIT     (REP)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .sel_cfg       (sel_cfg),
      .ro_bit_in     (ro_bit_in),
      .ro_activate_1 (ro_activate_1),
      .ro_activate_2 (ro_activate_2),
      .out_sel       (out_sel),
      .sbox_activate (sbox_activate),
      .sbox_in       (sbox_in),
      .sbox_out      (sbox_out),
      .rnd           (rnd_if.master),
      .busy          (busy),
      .health_fail   (health_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] sbox_tab [32];
   initial sbox_tab = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   // External ascon S-box with one registered cycle of latency.
   always @(posedge clk) sbox_out <= sbox_activate ? sbox_tab[sbox_in] : 5'd0;

   int   checks = 0;
   int   errors = 0;
   int   edge_no = 0;
   int   bit_mode = 0;
   logic bit_at [8192];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive this edge's raw bit, then advance one clock; outputs are read 1 ns after the edge.
   task automatic tick();
      case (bit_mode)
         1:       ro_bit_in = ((edge_no / DIV) % 2) == 1;
         2:       ro_bit_in = 1'b1;
         default: ro_bit_in = 1'($urandom_range(0, 1));
      endcase
      bit_at[edge_no] = ro_bit_in;
      @(posedge clk);
      #1;
      edge_no++;
   endtask

   task automatic wait_valid(input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (rnd_if.rnd_valid === 1'b1) begin
            at = edge_no - 1;
            break;
         end
      end
   endtask

   // Raw word assembled from the bits present at the eight sample edges after base.
   function automatic logic [7:0] word_from(input int base);
      logic [7:0] w = '0;
      for (int k = 1; k <= 8; k++) w = {w[6:0], bit_at[base + DIV * k]};
      return w;
   endfunction

   function automatic logic [7:0] whiten(input logic [7:0] w);
      return w ^ {3'b000, sbox_tab[w[4:0]]};
   endfunction

   int         e0, h, at, fail_at, nwords;
   logic [7:0] exp_word;

   initial begin
      rst_n = 1'b1;
      start = 1'b0;
      sel_cfg = 3'd0;
      ro_bit_in = 1'b0;
      rnd_if.rnd_ready = 1'b0;

      tick();
      tick();
      rst_n = 1'b0;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_ro1", 32'(ro_activate_1), 32'd0);
      check("reset_ro2", 32'(ro_activate_2), 32'd0);
      check("reset_out_sel", 32'(out_sel), 32'd0);
      check("reset_valid", 32'(rnd_if.rnd_valid), 32'd0);
      check("reset_data", 32'(rnd_if.rnd_data), 32'd0);
      check("reset_hfail", 32'(health_fail), 32'd0);
      check("reset_sbox_act", 32'(sbox_activate), 32'd0);
      tick();
      check("idle_no_start_busy", 32'(busy), 32'd0);

      // First word latency and whitening, toggling source, consumer always ready.
      bit_mode = 1;
      start = 1'b1;
      sel_cfg = 3'd5;
      rnd_if.rnd_ready = 1'b1;
      e0 = edge_no;
      tick();
      check("warmup_ro1", 32'(ro_activate_1), 32'd1);
      check("warmup_ro2", 32'(ro_activate_2), 32'd1);
      check("warmup_busy", 32'(busy), 32'd1);
      check("latched_sel", 32'(out_sel), 32'd5);
      wait_valid(200, at);
      check("first_word_latency", 32'(at - e0), 32'(SETTLE + WORD_LAT));
      check("first_word_data", 32'(rnd_if.rnd_data), 32'(whiten(word_from(e0 + SETTLE))));

      h = edge_no;
      tick();
      check("valid_drop_after_hs", 32'(rnd_if.rnd_valid), 32'd0);
      wait_valid(200, at);
      check("second_word_latency", 32'(at - h), 32'(WORD_LAT));
      exp_word = whiten(word_from(h));
      check("second_word_data", 32'(rnd_if.rnd_data), 32'(exp_word));

      // Back-pressure: word held, sel_cfg change ignored while running.
      rnd_if.rnd_ready = 1'b0;
      sel_cfg = 3'd2;
      bit_mode = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("hold_valid", 32'(rnd_if.rnd_valid), 32'd1);
         check("hold_data", 32'(rnd_if.rnd_data), 32'(exp_word));
      end
      check("sel_ignored", 32'(out_sel), 32'd5);
      rnd_if.rnd_ready = 1'b1;
      h = edge_no;
      tick();
      check("valid_drop_after_hold", 32'(rnd_if.rnd_valid), 32'd0);
      wait_valid(200, at);
      check("no_rewarm_latency", 32'(at - h), 32'(WORD_LAT));
      check("post_hold_data", 32'(rnd_if.rnd_data), 32'(whiten(word_from(h))));

      // Abort after three raw bits, then restart with a fresh warm-up.
      h = edge_no;
      tick();
      for (int i = 0; i < 3 * DIV; i++) tick();
      start = 1'b0;
      tick();
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ro1", 32'(ro_activate_1), 32'd0);
      check("abort_ro2", 32'(ro_activate_2), 32'd0);
      check("abort_valid", 32'(rnd_if.rnd_valid), 32'd0);
      for (int i = 0; i < 3; i++) tick();
      start = 1'b1;
      e0 = edge_no;
      wait_valid(200, at);
      check("restart_latency", 32'(at - e0), 32'(SETTLE + WORD_LAT));
      check("restart_data", 32'(rnd_if.rnd_data), 32'(whiten(word_from(e0 + SETTLE))));
      check("restart_sel", 32'(out_sel), 32'd2);

      // Reset asserted while the S-box is being driven.
      h = edge_no;
      tick();
      for (int i = 0; i < 8 * DIV; i++) tick();
      check("whiten_sbox_act", 32'(sbox_activate), 32'd1);
      check("whiten_sbox_in", 32'(sbox_in), 32'(word_from(h) & 8'h1f));
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_ro1", 32'(ro_activate_1), 32'd0);
      check("midrst_ro2", 32'(ro_activate_2), 32'd0);
      check("midrst_sbox_act", 32'(sbox_activate), 32'd0);
      check("midrst_sbox_in", 32'(sbox_in), 32'd0);
      check("midrst_data", 32'(rnd_if.rnd_data), 32'd0);
      check("midrst_valid", 32'(rnd_if.rnd_valid), 32'd0);
      check("midrst_out_sel", 32'(out_sel), 32'd0);
      tick();
      check("midrst_idle", 32'(busy), 32'd0);

      // Stuck source: REP_LIMIT samples span four words; the fourth never gets presented.
      bit_mode = 2;
      start = 1'b1;
      e0 = edge_no;
      nwords = 0;
      fail_at = -1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (rnd_if.rnd_valid === 1'b1) begin
            nwords++;
            check("stuck_word_data", 32'(rnd_if.rnd_data), 32'(whiten(8'hff)));
         end
         if (health_fail === 1'b1) begin
            fail_at = edge_no - 1;
            break;
         end
      end
      check("hfail_latency", 32'(fail_at - e0),
            32'(SETTLE + (REP / 8) * 8 * DIV + (REP / 8 - 1) * (SBOX_LAT + 2) + 1));
      check("stuck_words", 32'(nwords), 32'(REP / 8 - 1));
      check("fail_ro1", 32'(ro_activate_1), 32'd0);
      check("fail_ro2", 32'(ro_activate_2), 32'd0);
      check("fail_valid", 32'(rnd_if.rnd_valid), 32'd0);
      check("fail_busy", 32'(busy), 32'd0);
      check("fail_sbox_act", 32'(sbox_activate), 32'd0);
      for (int i = 0; i < 6; i++) begin
         start = (i % 2) == 0 ? 1'b0 : 1'b1;
         bit_mode = 0;
         tick();
         check("fail_sticky", 32'(health_fail), 32'd1);
      end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      rst_n = 1'b0;
      check("fail_cleared", 32'(health_fail), 32'd0);
      check("fail_cleared_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
